// File: rtl/p2048_pkg.sv
// Shared definitions for the 2048 game core and its VGA display end.
// Holds board geometry, 640x480@60 raster timing defaults, the 3-bit colour
// type and the tile-value-to-colour mapping.
package p2048_pkg;

  localparam int unsigned TILE_W  = 12;
  localparam int unsigned N_TILES = 16;
  localparam int unsigned CNT_W   = 10;

  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK = 3'b000;
  localparam rgb_t RGB_WHITE = 3'b111;
  localparam rgb_t RGB_GREEN = 3'b010;
  localparam rgb_t RGB_RED   = 3'b100;

  // Colour of a tile interior pixel. Anything that is not one of the listed
  // powers of two (>=256 or malformed) blinks between white and black.
  function automatic rgb_t tile_rgb(input logic [TILE_W-1:0] value, input logic centre,
                                    input logic blink);
    rgb_t c;
    case (value)
      12'd0:   c = RGB_BLACK;
      12'd2:   c = 3'b001;
      12'd4:   c = 3'b010;
      12'd8:   c = 3'b011;
      12'd16:  c = 3'b100;
      12'd32:  c = 3'b101;
      12'd64:  c = 3'b110;
      12'd128: c = centre ? RGB_BLACK : RGB_WHITE;
      default: c = blink ? RGB_WHITE : RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Raster timing generator.
//  clk_i/rst_ni   clock, synchronous active-low reset
//  pix_en_o       one-cycle pixel enable every PIX_DIV clocks
//  h_cnt_o/v_cnt_o raster position (stage 0)
//  hsync_o/vsync_o raw active-low syncs decoded from the counters
//  visible_o      position lies in the visible area
//  frame_start_o  pix_en at (0, V_VIS): first blanking line, snapshot point
//  frame_end_o    pix_en at the last raster position, counters wrap next
module vga_sync_gen
  import p2048_pkg::*;
#(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned H_VIS   = VGA_H_VIS,
  parameter int unsigned H_FP    = VGA_H_FP,
  parameter int unsigned H_SYNC  = VGA_H_SYNC,
  parameter int unsigned H_BP    = VGA_H_BP,
  parameter int unsigned V_VIS   = VGA_V_VIS,
  parameter int unsigned V_FP    = VGA_V_FP,
  parameter int unsigned V_SYNC  = VGA_V_SYNC,
  parameter int unsigned V_BP    = VGA_V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             visible_o,
  output logic             frame_start_o,
  output logic             frame_end_o
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DivW-1:0]  div_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
  logic             h_last, v_last;

  assign pix_en_o = (div_q == DivW'(PIX_DIV - 1));
  assign h_last   = (h_cnt_q == CNT_W'(HTotal - 1));
  assign v_last   = (v_cnt_q == CNT_W'(VTotal - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      div_q <= pix_en_o ? '0 : div_q + 1'b1;
      if (pix_en_o) begin
        if (h_last) begin
          h_cnt_q <= '0;
          v_cnt_q <= v_last ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_q <= h_cnt_q + 1'b1;
        end
      end
    end
  end

  assign h_cnt_o   = h_cnt_q;
  assign v_cnt_o   = v_cnt_q;
  assign hsync_o   = !((h_cnt_q >= CNT_W'(H_VIS + H_FP)) &&
                       (h_cnt_q <  CNT_W'(H_VIS + H_FP + H_SYNC)));
  assign vsync_o   = !((v_cnt_q >= CNT_W'(V_VIS + V_FP)) &&
                       (v_cnt_q <  CNT_W'(V_VIS + V_FP + V_SYNC)));
  assign visible_o = (h_cnt_q < CNT_W'(H_VIS)) && (v_cnt_q < CNT_W'(V_VIS));

  assign frame_start_o = pix_en_o && (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_VIS));
  assign frame_end_o   = pix_en_o && h_last && v_last;

endmodule

// File: rtl/board_vga_renderer.sv
// Display end of the 2048 board bus: snapshots the board once per frame and
// draws a 4x4 tile grid on a VGA raster with 1-bit R/G/B.
//  CLK/RESET_N      clock, synchronous active-low reset
//  board            16 x 12-bit tiles, tile k=4*row+col at [12k+11:12k]
//  win/lose         game status levels, colour the board frame
//  frame_tick       one-CLK pulse after the board snapshot is taken
//  vga_h_sync/v_sync active-low syncs, aligned with rgb
//  vga_r/g/b        pixel colour
module board_vga_renderer
  import p2048_pkg::*;
#(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned BOARD_X0 = 120,
  parameter int unsigned BOARD_Y0 = 40,
  parameter int unsigned TILE     = 100,
  parameter int unsigned BORDER   = 4,
  parameter int unsigned CENTRE   = 20,
  parameter int unsigned H_VIS    = VGA_H_VIS,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_VIS    = VGA_V_VIS,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [TILE_W*N_TILES-1:0] board,
  input  logic                      win,
  input  logic                      lose,
  output logic                      frame_tick,
  output logic                      vga_h_sync,
  output logic                      vga_v_sync,
  output logic                      vga_r,
  output logic                      vga_g,
  output logic                      vga_b
);

  localparam int unsigned OffW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int unsigned CLo  = TILE / 2 - CENTRE / 2;
  localparam int unsigned CHi  = CLo + CENTRE - 1;

  logic             pix_en, hs_raw, vs_raw, visible, frame_start, frame_end;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  vga_sync_gen #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_sync (
    .clk_i         (CLK),
    .rst_ni        (RESET_N),
    .pix_en_o      (pix_en),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .hsync_o       (hs_raw),
    .vsync_o       (vs_raw),
    .visible_o     (visible),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end)
  );

  // Shadow copy of the board, only updated during vertical blanking.
  logic [TILE_W-1:0] tiles_in [N_TILES];
  logic [TILE_W-1:0] tiles_q  [N_TILES];
  logic              win_q, lose_q, tick_q;
  logic [7:0]        frame_cnt_q;

  always_comb begin
    for (int k = 0; k < N_TILES; k++) begin
      tiles_in[k] = board[k*TILE_W +: TILE_W];
    end
  end

  // Stage 1: cell position of the point the counters held one pix_en ago.
  logic [OffW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [1:0]      col_q, col_d, row_q, row_d;
  logic            in_x_q, in_x_d, in_y_q, in_y_d;
  logic            vis1_q, hs1_q, vs1_q;
  // Stage 2: registered outputs.
  rgb_t            rgb_q, rgb_d;
  logic            hs2_q, vs2_q;

  always_comb begin
    ox_d   = ox_q;
    col_d  = col_q;
    in_x_d = in_x_q;
    if (h_cnt == CNT_W'(BOARD_X0)) begin
      ox_d   = '0;
      col_d  = '0;
      in_x_d = 1'b1;
    end else if (in_x_q) begin
      if (ox_q == OffW'(TILE - 1)) begin
        ox_d = '0;
        if (col_q == 2'd3) in_x_d = 1'b0;
        else               col_d  = col_q + 2'd1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end
  end

  // Vertical state steps once per line, at the h_cnt=0 pixel.
  always_comb begin
    oy_d   = oy_q;
    row_d  = row_q;
    in_y_d = in_y_q;
    if (v_cnt == CNT_W'(BOARD_Y0)) begin
      oy_d   = '0;
      row_d  = '0;
      in_y_d = 1'b1;
    end else if (in_y_q) begin
      if (oy_q == OffW'(TILE - 1)) begin
        oy_d = '0;
        if (row_q == 2'd3) in_y_d = 1'b0;
        else               row_d  = row_q + 2'd1;
      end else begin
        oy_d = oy_q + 1'b1;
      end
    end
  end

  logic [TILE_W-1:0] tile_val;
  logic              gx_lo, gx_hi, gy_lo, gy_hi, outer, centre;
  rgb_t              frame_rgb;

  always_comb begin
    tile_val  = tiles_q[{row_q, col_q}];
    gx_lo     = ox_q <  OffW'(BORDER);
    gx_hi     = ox_q >= OffW'(TILE - BORDER);
    gy_lo     = oy_q <  OffW'(BORDER);
    gy_hi     = oy_q >= OffW'(TILE - BORDER);
    outer     = (gx_lo && col_q == 2'd0) || (gx_hi && col_q == 2'd3) ||
                (gy_lo && row_q == 2'd0) || (gy_hi && row_q == 2'd3);
    centre    = (ox_q >= OffW'(CLo)) && (ox_q <= OffW'(CHi)) &&
                (oy_q >= OffW'(CLo)) && (oy_q <= OffW'(CHi));
    frame_rgb = win_q ? RGB_GREEN : (lose_q ? RGB_RED : RGB_WHITE);
    rgb_d     = RGB_BLACK;
    if (vis1_q && in_x_q && in_y_q) begin
      if (gx_lo || gx_hi || gy_lo || gy_hi) rgb_d = outer ? frame_rgb : RGB_WHITE;
      else                                  rgb_d = tile_rgb(tile_val, centre, frame_cnt_q[4]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tiles_q     <= '{default: '0};
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      tick_q      <= 1'b0;
      frame_cnt_q <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_x_q      <= 1'b0;
      in_y_q      <= 1'b0;
      vis1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      rgb_q       <= RGB_BLACK;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
    end else begin
      tick_q <= frame_start;
      if (frame_start) begin
        tiles_q <= tiles_in;
        win_q   <= win;
        lose_q  <= lose;
      end
      if (frame_end) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (pix_en) begin
        ox_q   <= ox_d;
        col_q  <= col_d;
        in_x_q <= in_x_d;
        if (h_cnt == '0) begin
          oy_q   <= oy_d;
          row_q  <= row_d;
          in_y_q <= in_y_d;
        end
        vis1_q <= visible;
        hs1_q  <= hs_raw;
        vs1_q  <= vs_raw;
        rgb_q  <= rgb_d;
        hs2_q  <= hs1_q;
        vs2_q  <= vs1_q;
      end
    end
  end

  assign frame_tick = tick_q;
  assign vga_h_sync = hs2_q;
  assign vga_v_sync = vs2_q;
  assign vga_r      = rgb_q[2];
  assign vga_g      = rgb_q[1];
  assign vga_b      = rgb_q[0];

endmodule

// File: tb/tb_board_vga_renderer.sv
// Randomised bench for board_vga_renderer on a shrunken raster so that many
// frames fit in a short run. A reference model derives every output pixel
// from its raster index with plain div/mod arithmetic.
module tb_board_vga_renderer;

  localparam int PIX_DIV = 2;
  localparam int X0 = 2, Y0 = 2, T = 8, B = 2, C = 2;
  localparam int H_VIS = 36, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 36, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;
  localparam int FRAME_CLK = FT * PIX_DIV;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [191:0] board = '0;
  logic         win = 1'b0, lose = 1'b0;
  logic         frame_tick, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_errors = 0;

  board_vga_renderer #(
    .PIX_DIV (PIX_DIV), .BOARD_X0 (X0), .BOARD_Y0 (Y0), .TILE (T), .BORDER (B), .CENTRE (C),
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .board      (board),
    .win        (win),
    .lose       (lose),
    .frame_tick (frame_tick),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what the display should have latched.
  logic [191:0] m_board = '0;
  bit           m_win = 1'b0, m_lose = 1'b0;
  int unsigned  n_edge = 0;

  function automatic int ref_tile(int val, bit centre, bit blink);
    if (val == 0) return 0;
    for (int k = 1; k <= 7; k++) begin
      if (val == (1 << k)) return (k == 7 && centre) ? 0 : k;
    end
    return blink ? 7 : 0;
  endfunction

  // Returns {hsync, vsync, rgb} for raster index p counted from reset release.
  function automatic int ref_px(int unsigned p);
    int h, v, f, x, y, ox, oy, rgb;
    bit hs, vs, gx, gy, outer, centre;
    h  = int'(p % HT);
    v  = int'((p / HT) % VT);
    f  = int'(p / FT);
    hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    rgb = 0;
    if (h < H_VIS && v < V_VIS && h >= X0 && h < X0 + 4*T && v >= Y0 && v < Y0 + 4*T) begin
      x  = h - X0;
      y  = v - Y0;
      ox = x % T;
      oy = y % T;
      gx = (ox < B) || (ox >= T - B);
      gy = (oy < B) || (oy >= T - B);
      if (gx || gy) begin
        outer = (x < B) || (x >= 4*T - B) || (y < B) || (y >= 4*T - B);
        rgb   = !outer ? 7 : (m_win ? 2 : (m_lose ? 4 : 7));
      end else begin
        centre = (ox >= T/2 - C/2) && (ox < T/2 - C/2 + C) &&
                 (oy >= T/2 - C/2) && (oy < T/2 - C/2 + C);
        rgb = ref_tile(int'(m_board[12*(4*(y/T) + x/T) +: 12]), centre, f[4]);
      end
    end
    return {hs, vs, 3'(rgb)};
  endfunction

  // Per-edge scoreboard. Raster advance k happens at edge k*PIX_DIV after
  // release; the point reached at advance p is shown at advance p+2.
  always @(posedge CLK) begin
    logic [191:0] b_s;
    bit           rn, w_s, l_s, tick_exp;
    int unsigned  a;
    int           e;
    rn  = RESET_N;
    b_s = board;
    w_s = win;
    l_s = lose;
    #1;
    if (!rn) begin
      n_edge  = 0;
      m_board = '0;
      m_win   = 1'b0;
      m_lose  = 1'b0;
      check_eq("rst_hsync", int'(vga_h_sync), 1);
      check_eq("rst_vsync", int'(vga_v_sync), 1);
      check_eq("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      check_eq("rst_tick", int'(frame_tick), 0);
    end else begin
      n_edge++;
      a = n_edge / PIX_DIV;
      e = (a < 2) ? 5'b11000 : ref_px(a - 2);
      tick_exp = (n_edge % PIX_DIV == 0) && (a >= 1) && ((a - 1) % FT == V_VIS * HT);
      check_eq("hsync", int'(vga_h_sync), e[4]);
      check_eq("vsync", int'(vga_v_sync), e[3]);
      check_eq("rgb", int'({vga_r, vga_g, vga_b}), e[2:0]);
      check_eq("frame_tick", int'(frame_tick), int'(tick_exp));
      if (tick_exp) begin
        m_board = b_s;
        m_win   = w_s;
        m_lose  = l_s;
      end
    end
  end

  function automatic logic [11:0] rand_val();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0)  return 12'd0;
    if (r <= 7)  return 12'(1 << r);
    if (r == 8)  return 12'd256;
    if (r == 9)  return 12'd2048;
    if (r == 10) return 12'($urandom_range(0, 4095));
    return 12'd6;
  endfunction

  task automatic mutate();
    int k;
    k = $urandom_range(0, 17);
    if (k == 16)      win  = $urandom_range(0, 1) == 1;
    else if (k == 17) lose = $urandom_range(0, 1) == 1;
    else              board[12*k +: 12] = rand_val();
  endtask

  int ticks;

  task automatic run_clks(input int n, input bit mut);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (mut && $urandom_range(0, 149) == 0) mutate();
      if (frame_tick) ticks++;
    end
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < 16; k++) board[12*k +: 12] = rand_val();
    run_clks(10, 1'b0);

    // Release and time the first hsync fall.
    RESET_N = 1'b1;
    cnt = 0;
    do begin
      @(posedge CLK);
      #2;
      cnt++;
    end while (vga_h_sync && cnt < 10 * FRAME_CLK);
    check_eq("first_hsync_fall", cnt, (H_VIS + H_FP + 2) * PIX_DIV);

    @(negedge CLK);
    run_clks(FRAME_CLK + FRAME_CLK / 2, 1'b1);

    // Single tile of 2, plain frame colour.
    board = '0;
    board[11:0] = 12'd2;
    win = 1'b0;
    lose = 1'b0;
    run_clks(2 * FRAME_CLK, 1'b0);

    // Mid-frame change must wait for the next snapshot.
    board[11:0] = 12'd4;
    run_clks(FRAME_CLK + FRAME_CLK / 2, 1'b0);

    // High-value tile blinks, 128 tile shows its hollow centre, frame colours.
    board[12*15 +: 12] = 12'd256;
    board[12*5 +: 12]  = 12'd128;
    lose = 1'b1;
    run_clks(4 * FRAME_CLK, 1'b0);
    win = 1'b1;
    ticks = 0;
    run_clks(FRAME_CLK, 1'b0);
    check_eq("ticks_per_frame", ticks, 1);
    run_clks(8 * FRAME_CLK, 1'b0);
    board[12*3 +: 12] = 12'd1000;
    win = 1'b0;
    run_clks(3 * FRAME_CLK, 1'b0);

    run_clks(FRAME_CLK, 1'b1);

    // Reset in the middle of a line, then keep running.
    run_clks($urandom_range(100, 2000), 1'b1);
    RESET_N = 1'b0;
    run_clks(3, 1'b0);
    RESET_N = 1'b1;
    run_clks(FRAME_CLK + FRAME_CLK / 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
